// File: rtl/bist_led_checker.sv
// Response analyser for the LED BIST walking fill/drain pattern.
// Locks onto the 9-cycle sequence, checks every sample and reports lock, pass/fail and error counts.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | checker parked; outputs hold; waits for bist_mode rising edge
// ST_HUNT  | searching for the 0000 -> 1000 alignment point; lock timeout runs
// ST_TRACK | aligned; every sample compared against the expected sequence
module bist_led_checker #(
  parameter int PASS_PERIODS = 4,
  parameter int LOCK_TIMEOUT = 32,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bist_mode,
  input  logic [3:0]       pattern,
  output logic             locked,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       period_cnt
);

  localparam int HW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int GW = $clog2(PASS_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [3:0]       prev_q;
  logic [HW-1:0]    hunt_cnt_q;
  logic [GW-1:0]    good_run_q;
  logic             prev_mode_q;
  logic             locked_q;
  logic             pass_q;
  logic             fail_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [7:0]       period_cnt_q;

  logic [3:0]       exp_d;
  logic             match_d;
  logic             arm_d;
  logic             lock_d;
  logic             timeout_d;
  logic [ERR_W-1:0] err_sat_d;
  logic [7:0]       period_sat_d;
  logic [GW-1:0]    good_inc_d;

  function automatic logic [3:0] exp_pat(input logic [3:0] i);
    logic [3:0] v;
    case (i)
      4'd0:    v = 4'b1000;
      4'd1:    v = 4'b1100;
      4'd2:    v = 4'b1110;
      4'd3:    v = 4'b1111;
      4'd4:    v = 4'b1110;
      4'd5:    v = 4'b1100;
      4'd6:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  always_comb begin
    exp_d        = exp_pat(idx_q);
    match_d      = (pattern == exp_d);
    arm_d        = bist_mode && !prev_mode_q;
    lock_d       = (prev_q == 4'b0000) && (pattern == 4'b1000);
    timeout_d    = (hunt_cnt_q == HW'(LOCK_TIMEOUT - 1));
    err_sat_d    = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    period_sat_d = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 8'd1;
    good_inc_d   = (good_run_q == GW'(PASS_PERIODS)) ? good_run_q : good_run_q + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      prev_q       <= '0;
      hunt_cnt_q   <= '0;
      good_run_q   <= '0;
      // Treat mode as already high so a held bist_mode cannot re-arm after reset.
      prev_mode_q  <= 1'b1;
      locked_q     <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      period_cnt_q <= '0;
    end else begin
      prev_mode_q <= bist_mode;
      case (state_q)
        ST_IDLE: begin
          if (arm_d) begin
            state_q      <= ST_HUNT;
            prev_q       <= pattern;
            idx_q        <= '0;
            hunt_cnt_q   <= '0;
            good_run_q   <= '0;
            locked_q     <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_cnt_q    <= '0;
            period_cnt_q <= '0;
          end
        end

        ST_HUNT: begin
          if (!bist_mode) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end else begin
            prev_q <= pattern;
            if (lock_d) begin
              state_q    <= ST_TRACK;
              idx_q      <= 4'd1;
              hunt_cnt_q <= '0;
              locked_q   <= 1'b1;
            end else if (timeout_d) begin
              fail_q     <= 1'b1;
              pass_q     <= 1'b0;
              err_cnt_q  <= err_sat_d;
              hunt_cnt_q <= '0;
            end else begin
              hunt_cnt_q <= hunt_cnt_q + HW'(1);
            end
          end
        end

        ST_TRACK: begin
          if (!bist_mode) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end else if (match_d) begin
            if (idx_q == 4'd8) begin
              idx_q        <= '0;
              period_cnt_q <= period_sat_d;
              good_run_q   <= good_inc_d;
              // fail is sticky until the next arm, so it permanently blocks pass.
              if ((good_inc_d == GW'(PASS_PERIODS)) && !fail_q) begin
                pass_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            state_q    <= ST_HUNT;
            err_cnt_q  <= err_sat_d;
            fail_q     <= 1'b1;
            pass_q     <= 1'b0;
            good_run_q <= '0;
            locked_q   <= 1'b0;
            prev_q     <= pattern;
            hunt_cnt_q <= '0;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = locked_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign err_cnt    = err_cnt_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_bist_led_checker.sv
// Self-checking bench for bist_led_checker: cycle scoreboard against a behavioural model,
// plus directed checks at the key cycles of each scenario.
module tb_bist_led_checker;

  localparam int LT = 32;
  localparam int PP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bist_mode = 1'b0;
  logic [3:0] pattern = 4'b0000;

  logic       locked, pass, fail;
  logic [7:0] err_cnt, period_cnt;
  logic       locked2, pass2, fail2;
  logic [1:0] err_cnt2;
  logic [7:0] period_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  int EXPV[9] = '{8, 12, 14, 15, 14, 12, 8, 0, 0};

  always #5 clk = ~clk;

  bist_led_checker #(.PASS_PERIODS(PP), .LOCK_TIMEOUT(LT), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .bist_mode(bist_mode), .pattern(pattern),
    .locked(locked), .pass(pass), .fail(fail), .err_cnt(err_cnt), .period_cnt(period_cnt)
  );

  bist_led_checker #(.PASS_PERIODS(PP), .LOCK_TIMEOUT(LT), .ERR_W(2)) u_dut_e2 (
    .clk(clk), .rst(rst), .bist_mode(bist_mode), .pattern(pattern),
    .locked(locked2), .pass(pass2), .fail(fail2), .err_cnt(err_cnt2), .period_cnt(period_cnt2)
  );

  typedef struct {
    int st, idx, hunt, prev, pm, locked, pass, fail, err, per, good;
  } mstate_t;

  typedef struct {
    int locked, pass, fail, err, per;
    int locked2, pass2, fail2, err2, per2;
  } exp_t;

  mstate_t m8, m2;
  exp_t    sb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: st 0=idle 1=hunt 2=track.
  function automatic mstate_t step(input mstate_t s, input int r, input int m, input int p,
                                   input int errmax);
    mstate_t n;
    n = s;
    if (r != 0) begin
      n = '{default: 0};
      n.pm = 1;
      return n;
    end
    n.pm = m;
    if (s.st == 0) begin
      if (s.pm == 0 && m == 1) begin
        n.st = 1; n.prev = p; n.idx = 0; n.hunt = 0; n.good = 0;
        n.locked = 0; n.pass = 0; n.fail = 0; n.err = 0; n.per = 0;
      end
    end else if (m == 0) begin
      n.st = 0; n.locked = 0;
    end else if (s.st == 1) begin
      n.prev = p;
      if (s.prev == 0 && p == 8) begin
        n.st = 2; n.idx = 1; n.hunt = 0; n.locked = 1;
      end else if (s.hunt == LT - 1) begin
        n.fail = 1; n.pass = 0; n.hunt = 0;
        if (s.err < errmax) n.err = s.err + 1;
      end else begin
        n.hunt = s.hunt + 1;
      end
    end else begin
      if (p == EXPV[s.idx]) begin
        if (s.idx == 8) begin
          n.idx = 0;
          if (s.per < 255) n.per = s.per + 1;
          n.good = s.good + 1;
          if (n.good >= PP && s.fail == 0) n.pass = 1;
        end else begin
          n.idx = s.idx + 1;
        end
      end else begin
        if (s.err < errmax) n.err = s.err + 1;
        n.fail = 1; n.pass = 0; n.good = 0; n.locked = 0;
        n.st = 1; n.prev = p; n.hunt = 0;
      end
    end
    return n;
  endfunction

  task automatic cyc(input bit r, input bit m, input logic [3:0] p);
    exp_t e;
    rst = r; bist_mode = m; pattern = p;
    m8 = step(m8, int'(r), int'(m), int'(p), 255);
    m2 = step(m2, int'(r), int'(m), int'(p), 3);
    sb.push_back('{m8.locked, m8.pass, m8.fail, m8.err, m8.per,
                   m2.locked, m2.pass, m2.fail, m2.err, m2.per});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_locked", int'(locked), e.locked);
    chk("sb_pass", int'(pass), e.pass);
    chk("sb_fail", int'(fail), e.fail);
    chk("sb_err", int'(err_cnt), e.err);
    chk("sb_period", int'(period_cnt), e.per);
    chk("sb_locked_e2", int'(locked2), e.locked2);
    chk("sb_pass_e2", int'(pass2), e.pass2);
    chk("sb_fail_e2", int'(fail2), e.fail2);
    chk("sb_err_e2", int'(err_cnt2), e.err2);
    chk("sb_period_e2", int'(period_cnt2), e.per2);
    chk("pass_and_fail", int'(pass & fail), 0);
  endtask

  task automatic ideal(input int start, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'(EXPV[(start + i) % 9]));
  endtask

  task automatic stuck(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m8 = '{default: 0};
    m2 = '{default: 0};

    // 1: reset, arm, ideal stream; 1000 sampled at cycle k
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_period", int'(period_cnt), 0);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h0);
    ideal(8, 1);
    chk("t1_not_locked_yet", int'(locked), 0);
    ideal(0, 1);
    chk("t1_locked_k1", int'(locked), 1);
    ideal(1, 8);
    chk("t1_period_k9", int'(period_cnt), 1);
    ideal(0, 26);
    chk("t1_pass_k35", int'(pass), 0);
    chk("t1_period_k35", int'(period_cnt), 3);
    ideal(8, 1);
    chk("t1_pass_k36", int'(pass), 1);
    chk("t1_period_k36", int'(period_cnt), 4);
    chk("t1_err", int'(err_cnt), 0);
    chk("t1_fail", int'(fail), 0);

    // 2: corrupt idx 2 of the second period
    cyc(1'b0, 1'b0, 4'h0);
    chk("t2_drop_pass_hold", int'(pass), 1);
    chk("t2_drop_unlock", int'(locked), 0);
    cyc(1'b0, 1'b1, 4'h0);
    chk("t2_arm_pass_clr", int'(pass), 0);
    chk("t2_arm_period_clr", int'(period_cnt), 0);
    ideal(8, 1);
    ideal(0, 1);
    ideal(1, 8);
    ideal(0, 2);
    cyc(1'b0, 1'b1, 4'b1010);
    chk("t2_fail", int'(fail), 1);
    chk("t2_unlock", int'(locked), 0);
    chk("t2_err", int'(err_cnt), 1);
    chk("t2_pass", int'(pass), 0);
    ideal(3, 6);
    chk("t2_still_hunting", int'(locked), 0);
    ideal(0, 1);
    chk("t2_relock", int'(locked), 1);
    ideal(1, 44);
    chk("t2_pass_blocked", int'(pass), 0);
    chk("t2_period", int'(period_cnt), 6);
    chk("t2_err_final", int'(err_cnt), 1);

    // 3: stuck at 0000 -> lock timeouts
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h0);
    stuck(4'h0, 31);
    chk("t3_err_31", int'(err_cnt), 0);
    chk("t3_fail_31", int'(fail), 0);
    stuck(4'h0, 1);
    chk("t3_err_32", int'(err_cnt), 1);
    chk("t3_fail_32", int'(fail), 1);
    stuck(4'h0, 32);
    chk("t3_err_64", int'(err_cnt), 2);
    chk("t3_locked", int'(locked), 0);

    // 4: stuck at 1111, 2-bit counter saturates at 3
    cyc(1'b0, 1'b0, 4'hF);
    cyc(1'b0, 1'b1, 4'hF);
    stuck(4'hF, 64);
    chk("t4_e2_err_64", int'(err_cnt2), 2);
    stuck(4'hF, 64);
    chk("t4_e2_err_128", int'(err_cnt2), 3);
    chk("t4_err_128", int'(err_cnt), 4);
    stuck(4'hF, 32);
    chk("t4_e2_err_sat", int'(err_cnt2), 3);
    chk("t4_err_160", int'(err_cnt), 5);

    // 5: drop bist_mode mid-period, then re-arm
    cyc(1'b0, 1'b0, 4'h0);
    chk("t5_err_hold_prev", int'(err_cnt), 5);
    cyc(1'b0, 1'b1, 4'h0);
    chk("t5_err_clr", int'(err_cnt), 0);
    ideal(8, 1);
    ideal(0, 1);
    ideal(1, 8);
    ideal(0, 4);
    cyc(1'b0, 1'b0, 4'(EXPV[4]));
    chk("t5_unlock", int'(locked), 0);
    chk("t5_period_hold", int'(period_cnt), 1);
    cyc(1'b0, 1'b0, 4'h8);
    cyc(1'b0, 1'b0, 4'hC);
    chk("t5_period_hold2", int'(period_cnt), 1);
    cyc(1'b0, 1'b1, 4'h0);
    chk("t5_rearm_period", int'(period_cnt), 0);
    chk("t5_rearm_locked", int'(locked), 0);
    ideal(8, 1);
    ideal(0, 1);
    chk("t5_relock", int'(locked), 1);

    // 6: reset mid-TRACK with bist_mode held high
    ideal(1, 5);
    cyc(1'b1, 1'b1, 4'(EXPV[6]));
    chk("t6_rst_locked", int'(locked), 0);
    chk("t6_rst_period", int'(period_cnt), 0);
    chk("t6_rst_err", int'(err_cnt), 0);
    ideal(7, 20);
    chk("t6_no_relock", int'(locked), 0);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h0);
    ideal(8, 1);
    ideal(0, 1);
    chk("t6_relock_after_toggle", int'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_led_checker.md
Name: bist_led_checker

Overview:
- Response analyser for the LED BIST pattern generator. It sits on the 4-bit LED bus, on the same clock as the generator.
- While BIST mode is active, it locks onto the walking fill/drain pattern, checks every cycle against the expected sequence, and reports lock, pass/fail and an error count.
- It is the receiving end of the generator's pattern stream and is used for board self-test and simulation sign-off.

Parameters:
PASS_PERIODS, 4, number of consecutive error-free full periods required before pass asserts
LOCK_TIMEOUT, 32, cycles allowed in HUNT without lock before a timeout error is logged
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
bist_mode  input  1  1 = generator in BIST mode (switches all zero); checker active
pattern  input  4  LED bus value from the generator, sampled every clk
locked  output  1  checker is aligned to the pattern sequence
pass  output  1  sticky; PASS_PERIODS clean periods with no error since arm
fail  output  1  sticky; at least one error since arm
err_cnt  output  ERR_W  saturating count of mismatches plus timeouts
period_cnt  output  8  count of clean full periods since arm, saturates at 255

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, idx=0, hunt_cnt=0, prev=0000.
- Expected sequence, period 9, idx 0..8: 1000, 1100, 1110, 1111, 1110, 1100, 1000, 0000, 0000.
- All outputs are registered. The effect of a sample at cycle n is visible at cycle n+1.

State IDLE:
- Outputs hold their last values.
- bist_mode rising (prev_mode=0, bist_mode=1) arms the checker:
  - clear pass, fail, err_cnt, period_cnt, good_run.
  - go to HUNT.
  - set prev to the current pattern.

State HUNT:
- locked=0. Each cycle: prev <= pattern, hunt_cnt++.
- prev==0000 and pattern==1000: go to TRACK with idx=1, hunt_cnt=0. locked=1 from the next cycle.
- hunt_cnt reaches LOCK_TIMEOUT-1 without lock: fail=1, err_cnt++ (saturating), hunt_cnt=0, stay in HUNT.

State TRACK:
- Each cycle, compare pattern with exp[idx].
- Match: idx advances, wrapping 8 to 0.
  - On a match at idx==8: period_cnt++ (saturating) and good_run++.
  - When good_run reaches PASS_PERIODS and fail==0: pass=1.
- Mismatch: err_cnt++ (saturating), fail=1, pass=0, good_run=0, locked=0, go to HUNT.
  - prev <= pattern.
  - hunt_cnt=0.

Boundary conditions:
- pass and fail are never both 1. fail overrides and clears pass. Once fail=1, pass cannot reassert until the next arm.
- err_cnt saturates at all-ones and never wraps. period_cnt saturates at 255.
- Timeout and mismatch cannot coincide, because they occur in different states.
- bist_mode falling in any state: go to IDLE next cycle and set locked=0. pass, fail, err_cnt and period_cnt hold for readout.
- bist_mode rising while already in HUNT/TRACK cannot occur, since leaving IDLE requires the rising edge.
- rst overrides everything at any cycle, including mid-TRACK. State returns to IDLE even if bist_mode=1; the checker re-arms only on a new rising edge of bist_mode.
- A pattern of 0000 repeated more than twice while in TRACK is a mismatch at idx 0.

Test Plan:
1. Arm, then drive the ideal stream 0000, 0000, 1000, 1100, … continuously. The cycle where 1000 is sampled is k.
   -> locked=1 at k+1; period_cnt=1 at k+9; pass=1 at k+36; err_cnt=0; fail=0.
2. Ideal stream, then corrupt one sample (1110 -> 1010 at idx 2) in the 2nd period.
   -> next cycle: fail=1, locked=0, err_cnt=1, pass=0.
   -> relock on the next 0000→1000, then pass stays 0.
3. Arm, drive pattern stuck at 0000.
   -> fail=1 and err_cnt=1 after 32 cycles; err_cnt=2 after 64; locked stays 0.
4. ERR_W=2, pattern stuck at 1111.
   -> err_cnt climbs 1, 2, 3 and holds at 3 (no wrap).
5. Lock, then drop bist_mode mid-period.
   -> locked=0 next cycle; period_cnt/err_cnt hold.
   -> raise bist_mode again: all counters clear; HUNT restarts.
6. Assert rst for 1 cycle mid-TRACK while bist_mode=1.
   -> all outputs 0, IDLE; no relock until bist_mode toggles 0→1.
